// File: rtl/regfile_alu_datapath_if.sv
// Operation/result bundle between the control FSMs and regfile_alu_datapath.
// Master issues one ALU operation per cycle; slave is the datapath.
interface regfile_alu_datapath_if;
   logic [7:0]  alu_op;
   logic [7:0]  muxes;
   logic [15:0] regs_en;
   logic [15:0] imm;
   logic [15:0] result;
   logic [15:0] result_q;
   logic [4:0]  flags;
   logic [3:0]  dbg_sel;
   logic [15:0] dbg_data;

   modport master (
      output alu_op, muxes, regs_en, imm, dbg_sel,
      input  result, result_q, flags, dbg_data
   );

   modport slave (
      input  alu_op, muxes, regs_en, imm, dbg_sel,
      output result, result_q, flags, dbg_data
   );
endinterface

// File: rtl/regfile_alu_datapath.sv
// 16x16 register file, operand muxes, 8-bit-opcode ALU, PSR flags and display latch.
// Optional DATAPATH_FLAGS_EN: enables PSR flags {C,L,F,Z,N}, ADDC carry-in and CMP/CMPI.
module regfile_alu_datapath #(
   parameter int unsigned DATA_W    = 16,
   parameter logic [15:0] REG_RESET = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   regfile_alu_datapath_if.slave bus
);

   typedef enum logic [3:0] {
      OP_NONE, OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_CMP,
      OP_AND, OP_OR, OP_XOR, OP_MOV, OP_LSH, OP_LUI
   } op_e;

`ifdef DATAPATH_FLAGS_EN
   localparam int unsigned SW = DATA_W + 1;
`else
   localparam int unsigned SW = DATA_W;
`endif

   logic [DATA_W-1:0] regs [16];
   logic [DATA_W-1:0] a, b, res, shifted, result_q_r;
   logic [SW-1:0]     sum, diff;
   logic [4:0]        sh, sh_mag;
   logic              use_imm, cin, wr_ok;
   op_e               op;

   always_comb begin
      op      = OP_NONE;
      use_imm = 1'b0;
      case (bus.alu_op)
         8'h05: op = OP_ADD;
         8'h50: begin op = OP_ADD;  use_imm = 1'b1; end
         8'h06: op = OP_ADDU;
         8'h60: begin op = OP_ADDU; use_imm = 1'b1; end
         8'h07: op = OP_ADDC;
         8'h70: begin op = OP_ADDC; use_imm = 1'b1; end
         8'h09: op = OP_SUB;
         8'h90: begin op = OP_SUB;  use_imm = 1'b1; end
`ifdef DATAPATH_FLAGS_EN
         8'h0B: op = OP_CMP;
         8'hB0: begin op = OP_CMP;  use_imm = 1'b1; end
`endif
         8'h01: op = OP_AND;
         8'h10: begin op = OP_AND;  use_imm = 1'b1; end
         8'h02: op = OP_OR;
         8'h20: begin op = OP_OR;   use_imm = 1'b1; end
         8'h03: op = OP_XOR;
         8'h30: begin op = OP_XOR;  use_imm = 1'b1; end
         8'h0D: op = OP_MOV;
         8'hD0: begin op = OP_MOV;  use_imm = 1'b1; end
         8'h84: op = OP_LSH;
         8'h80: begin op = OP_LSH;  use_imm = 1'b1; end
         8'hF0: begin op = OP_LUI;  use_imm = 1'b1; end
         default: ;
      endcase
   end

   // Reads see the pre-edge register contents; there is no write-to-read bypass.
   always_comb begin
      a = regs[bus.muxes[7:4]];
      b = use_imm ? bus.imm : regs[bus.muxes[3:0]];
   end

`ifdef DATAPATH_FLAGS_EN
   logic [4:0] flags_q;
   always_comb cin = (op == OP_ADDC) ? flags_q[4] : 1'b0;
`else
   always_comb cin = 1'b0;
`endif

   // Shift amount is a signed 5-bit value; a right shift by 16 yields 0 naturally.
   always_comb begin
      sh      = b[4:0];
      sh_mag  = sh[4] ? (5'd0 - sh) : sh;
      shifted = sh[4] ? (a >> sh_mag) : (a << sh_mag);
      sum     = SW'(a) + SW'(b) + SW'(cin);
      diff    = SW'(a) - SW'(b);
   end

   always_comb begin
      res = '0;
      case (op)
         OP_ADD, OP_ADDU, OP_ADDC: res = sum[DATA_W-1:0];
         OP_SUB, OP_CMP:           res = diff[DATA_W-1:0];
         OP_AND:                   res = a & b;
         OP_OR:                    res = a | b;
         OP_XOR:                   res = a ^ b;
         OP_MOV:                   res = b;
         OP_LSH:                   res = shifted;
         OP_LUI:                   res = {bus.imm[7:0], 8'h00};
         default:                  res = '0;
      endcase
   end

   always_comb wr_ok = (op != OP_NONE) && (op != OP_CMP);

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 16; i++) regs[i] <= REG_RESET;
         result_q_r <= '0;
      end else if (wr_ok) begin
         for (int unsigned i = 0; i < 16; i++)
            if (bus.regs_en[i]) regs[i] <= res;
         if (|bus.regs_en) result_q_r <= res;
      end
   end

`ifdef DATAPATH_FLAGS_EN
   // flags_q = {C, L, F, Z, N}; each op touches only its own subset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         case (op)
            OP_ADD, OP_ADDC: begin
               flags_q[4] <= sum[DATA_W];
               flags_q[2] <= (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            OP_SUB: begin
               flags_q[4] <= diff[DATA_W];
               flags_q[2] <= (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
            end
            OP_CMP: begin
               flags_q[3] <= diff[DATA_W];
               flags_q[1] <= (a == b);
               flags_q[0] <= ($signed(a) < $signed(b));
            end
            default: ;
         endcase
      end
   end
   assign bus.flags = flags_q;
`else
   assign bus.flags = '0;
`endif

   assign bus.result   = res;
   assign bus.result_q = result_q_r;
   assign bus.dbg_data = regs[bus.dbg_sel];

endmodule

// File: tb/tb_regfile_alu_datapath.sv
// Directed, table-driven bench for regfile_alu_datapath; honours DATAPATH_FLAGS_EN.
module tb_regfile_alu_datapath;

`ifdef DATAPATH_FLAGS_EN
   localparam bit FLAGS_ON = 1'b1;
`else
   localparam bit FLAGS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   regfile_alu_datapath_if bus ();

   regfile_alu_datapath #(.DATA_W(16), .REG_RESET(16'h0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  mx;
      logic [15:0] en;
      logic [15:0] imm;
      logic [15:0] res;
      logic [3:0]  sel;
      logic [15:0] reg_v;
      logic [15:0] q;
      logic [4:0]  fl;
   } vec_t;

   vec_t vt[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [7:0] op, input logic [7:0] mx, input logic [15:0] en,
                        input logic [15:0] imm, input logic [3:0] sel);
      @(negedge clk);
      bus.alu_op  = op;
      bus.muxes   = mx;
      bus.regs_en = en;
      bus.imm     = imm;
      bus.dbg_sel = sel;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string name, input logic [15:0] exp);
      for (int r = 0; r < 16; r++) begin
         bus.dbg_sel = 4'(r);
         #1;
         check($sformatf("%s R%0d", name, r), bus.dbg_data, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] op, input logic [7:0] mx, input logic [15:0] en,
                               input logic [15:0] imm, input logic [15:0] res, input logic [3:0] sel,
                               input logic [15:0] reg_v, input logic [15:0] q, input logic [4:0] fl);
      vec_t v;
      v = '{op, mx, en, imm, res, sel, reg_v, q, fl};
      return v;
   endfunction

   initial begin
      int fa, fb, fn;
      logic [4:0] exp_fl;

      // flags below are {C,L,F,Z,N} as they stand after each vector
      vt.push_back(mk(8'h50, 8'h10, 16'h0002, 16'h0001, 16'h0001, 4'd1, 16'h0001, 16'h0001, 5'b00000));
      fa = 0; fb = 1;
      for (int n = 2; n < 16; n++) begin
         fn = fa + fb;
         vt.push_back(mk(8'h05, {4'(n - 2), 4'(n - 1)}, 16'(1 << n), 16'h0000,
                         16'(fn), 4'(n), 16'(fn), 16'(fn), 5'b00000));
         fa = fb; fb = fn;
      end
      vt.push_back(mk(8'hD0, 8'h00, 16'h0002, 16'hFFFF, 16'hFFFF, 4'd1, 16'hFFFF, 16'hFFFF, 5'b00000));
      vt.push_back(mk(8'hD0, 8'h00, 16'h0004, 16'h0001, 16'h0001, 4'd2, 16'h0001, 16'h0001, 5'b00000));
      vt.push_back(mk(8'h05, 8'h12, 16'h0008, 16'h0000, 16'h0000, 4'd3, 16'h0000, 16'h0000, 5'b10000));
      vt.push_back(mk(8'hD0, 8'h00, 16'h0002, 16'h7FFF, 16'h7FFF, 4'd1, 16'h7FFF, 16'h7FFF, 5'b10000));
      vt.push_back(mk(8'h05, 8'h12, 16'h0008, 16'h0000, 16'h8000, 4'd3, 16'h8000, 16'h8000, 5'b00100));
      vt.push_back(mk(8'h09, 8'h21, 16'h0010, 16'h0000, 16'h8002, 4'd4, 16'h8002, 16'h8002, 5'b10000));
      vt.push_back(mk(8'h06, 8'h33, 16'h0020, 16'h0000, 16'h0000, 4'd5, 16'h0000, 16'h0000, 5'b10000));
      vt.push_back(mk(8'h07, 8'h22, 16'h0040, 16'h0000, FLAGS_ON ? 16'h0003 : 16'h0002, 4'd6,
                      FLAGS_ON ? 16'h0003 : 16'h0002, FLAGS_ON ? 16'h0003 : 16'h0002, 5'b00000));
      vt.push_back(mk(8'h01, 8'h12, 16'h0080, 16'h0000, 16'h0001, 4'd7, 16'h0001, 16'h0001, 5'b00000));
      vt.push_back(mk(8'h20, 8'h20, 16'h0100, 16'h00F0, 16'h00F1, 4'd8, 16'h00F1, 16'h00F1, 5'b00000));
      vt.push_back(mk(8'h30, 8'h10, 16'h0200, 16'hFFFF, 16'h8000, 4'd9, 16'h8000, 16'h8000, 5'b00000));
      vt.push_back(mk(8'h03, 8'h89, 16'h0400, 16'h0000, 16'h80F1, 4'd10, 16'h80F1, 16'h80F1, 5'b00000));
      vt.push_back(mk(8'h0D, 8'h0A, 16'h0800, 16'h0000, 16'h80F1, 4'd11, 16'h80F1, 16'h80F1, 5'b00000));
      vt.push_back(mk(8'hD0, 8'h00, 16'h0010, 16'h0081, 16'h0081, 4'd4, 16'h0081, 16'h0081, 5'b00000));
      vt.push_back(mk(8'h80, 8'h40, 16'h1000, 16'h0004, 16'h0810, 4'd12, 16'h0810, 16'h0810, 5'b00000));
      vt.push_back(mk(8'h80, 8'h40, 16'h2000, 16'h001C, 16'h0008, 4'd13, 16'h0008, 16'h0008, 5'b00000));
      vt.push_back(mk(8'h80, 8'h40, 16'h4000, 16'h0010, 16'h0000, 4'd14, 16'h0000, 16'h0000, 5'b00000));
      vt.push_back(mk(8'h84, 8'h42, 16'h8000, 16'h0000, 16'h0102, 4'd15, 16'h0102, 16'h0102, 5'b00000));
      vt.push_back(mk(8'hF0, 8'h00, 16'h0020, 16'h12AB, 16'hAB00, 4'd5, 16'hAB00, 16'hAB00, 5'b00000));
      vt.push_back(mk(8'h50, 8'h20, 16'h0003, 16'h0001, 16'h0002, 4'd0, 16'h0002, 16'h0002, 5'b00000));
      vt.push_back(mk(8'h90, 8'h00, 16'h0000, 16'h0003, 16'hFFFF, 4'd0, 16'h0002, 16'h0002, 5'b10000));
      vt.push_back(mk(8'hEE, 8'h00, 16'hFFFF, 16'h0000, 16'h0000, 4'd0, 16'h0002, 16'h0002, 5'b10000));
      vt.push_back(mk(8'h00, 8'h00, 16'hFFFF, 16'h0000, 16'h0000, 4'd1, 16'h0002, 16'h0002, 5'b10000));
      vt.push_back(mk(8'h02, 8'h27, 16'h0001, 16'h0000, 16'h0001, 4'd0, 16'h0001, 16'h0001, 5'b10000));
      vt.push_back(mk(8'h05, 8'h33, 16'h0002, 16'h0000, 16'h0000, 4'd1, 16'h0000, 16'h0000, 5'b10100));

      reset = 1'b0;
      bus.alu_op = 8'h00; bus.muxes = 8'h00; bus.regs_en = 16'h0000; bus.imm = 16'h0000; bus.dbg_sel = 4'd0;
      tick(); tick();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_regs("reset", 16'h0000);
      check("reset result_q", bus.result_q, 16'h0000);
      check("reset flags", 16'(bus.flags), 16'h0000);

      foreach (vt[i]) begin
         drive(vt[i].op, vt[i].mx, vt[i].en, vt[i].imm, vt[i].sel);
         check($sformatf("v%0d result", i), bus.result, vt[i].res);
         tick();
         exp_fl = FLAGS_ON ? vt[i].fl : 5'b00000;
         check($sformatf("v%0d R%0d", i, vt[i].sel), bus.dbg_data, vt[i].reg_v);
         check($sformatf("v%0d result_q", i), bus.result_q, vt[i].q);
         check($sformatf("v%0d flags", i), 16'(bus.flags), 16'(exp_fl));
      end

      // CMP: all-ones regs_en must not write; only L/Z/N move. Entry flags = 10100.
      drive(8'hD0, 8'h00, 16'h0002, 16'h0003, 4'd1); tick();
      check("mov3 R1", bus.dbg_data, 16'h0003);
      drive(8'hB0, 8'h10, 16'hFFFF, 16'h0005, 4'd1);
      if (!FLAGS_ON) check("cmpi off result", bus.result, 16'h0000);
      tick();
      check("cmpi3 R1", bus.dbg_data, 16'h0003);
      check("cmpi3 result_q", bus.result_q, 16'h0003);
      check("cmpi3 flags", 16'(bus.flags), FLAGS_ON ? 16'(5'b11101) : 16'h0000);
      bus.dbg_sel = 4'd0; #1;
      check("cmpi3 R0", bus.dbg_data, 16'h0001);
      drive(8'hD0, 8'h00, 16'h0002, 16'hFFFF, 4'd1); tick();
      drive(8'hB0, 8'h10, 16'hFFFF, 16'h0005, 4'd1); tick();
      check("cmpim1 R1", bus.dbg_data, 16'hFFFF);
      check("cmpim1 result_q", bus.result_q, 16'hFFFF);
      check("cmpim1 flags", 16'(bus.flags), FLAGS_ON ? 16'(5'b10101) : 16'h0000);
      drive(8'hB0, 8'h10, 16'hFFFF, 16'hFFFF, 4'd1); tick();
      check("cmpi eq flags", 16'(bus.flags), FLAGS_ON ? 16'(5'b10110) : 16'h0000);
      drive(8'h0B, 8'h12, 16'hFFFF, 16'h0000, 4'd2); tick();
      check("cmp reg flags", 16'(bus.flags), FLAGS_ON ? 16'(5'b10101) : 16'h0000);
      check("cmp reg R2", bus.dbg_data, 16'h0001);

      // Reset asserted together with a broadcast write: reset must win.
      drive(8'h50, 8'h00, 16'hFFFF, 16'h0005, 4'd0);
      reset = 1'b0;
      tick();
      @(negedge clk);
      reset = 1'b1;
      bus.alu_op = 8'h00; bus.regs_en = 16'h0000;
      #1;
      check_regs("midreset", 16'h0000);
      check("midreset result_q", bus.result_q, 16'h0000);
      check("midreset flags", 16'(bus.flags), 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
